// File: rtl/branch_predict_unit_if.sv
// IF-lookup and MEM-resolution signal bundle for branch_predict_unit.
// slave = predictor side, master = pipeline side driving PCs and MEM results.
interface branch_predict_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic [XLEN-1:0]  pc_if;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;
    logic [XLEN-1:0]  next_pc;

    logic             mem_valid;
    logic             mem_branch;
    logic             mem_alu_branch;
    logic             mem_branchjalx;
    logic [XLEN-1:0]  mem_pc;
    logic [XLEN-1:0]  mem_target;
    logic             mem_pred_taken;
    logic [XLEN-1:0]  mem_pred_target;

    logic             pcsrc;
    logic [XLEN-1:0]  redirect_pc;
    logic             ifflush;
    logic             idflush;
    logic             exflush;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] mis_cnt;

    modport slave (
        input  pc_if, mem_valid, mem_branch, mem_alu_branch, mem_branchjalx,
               mem_pc, mem_target, mem_pred_taken, mem_pred_target,
        output pred_taken, pred_target, next_pc, pcsrc, redirect_pc,
               ifflush, idflush, exflush, br_cnt, mis_cnt
    );

    modport master (
        output pc_if, mem_valid, mem_branch, mem_alu_branch, mem_branchjalx,
               mem_pc, mem_target, mem_pred_taken, mem_pred_target,
        input  pred_taken, pred_target, next_pc, pcsrc, redirect_pc,
               ifflush, idflush, exflush, br_cnt, mis_cnt
    );
endinterface

// File: rtl/branch_predict_unit.sv
// Direct-mapped BHT + tagged BTB predictor with MEM-stage resolution and saturating stats.
// Lookup/resolve are combinational; tables and counters update on the next edge; no stalls.
module branch_predict_unit #(
    parameter int XLEN       = 32,
    parameter int IDX_BITS   = 6,
    parameter bit PREDICT_EN = 1'b1,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_predict_unit_if.slave  bus
);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = XLEN - IDX_BITS - 2;

    logic [ENTRIES-1:0][1:0]       bht_q;
    logic [ENTRIES-1:0]            vld_q;
    logic [ENTRIES-1:0][TAG_W-1:0] tag_q;
    logic [ENTRIES-1:0][XLEN-1:0]  tgt_q;
    logic [CNT_W-1:0]              br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0]              mis_cnt_q, mis_cnt_d;

    logic [IDX_BITS-1:0] idx_if, idx_m;
    logic [TAG_W-1:0]    tag_if, tag_m;
    logic                hit, rb, actual, mispredict;
    logic [1:0]          cnt_d;

    assign idx_if = bus.pc_if[IDX_BITS+1:2];
    assign tag_if = bus.pc_if[XLEN-1:IDX_BITS+2];
    assign idx_m  = bus.mem_pc[IDX_BITS+1:2];
    assign tag_m  = bus.mem_pc[XLEN-1:IDX_BITS+2];

    assign hit             = vld_q[idx_if] && (tag_q[idx_if] == tag_if);
    assign bus.pred_taken  = PREDICT_EN ? (hit && bht_q[idx_if][1]) : 1'b0;
    assign bus.pred_target = tgt_q[idx_if];

    assign rb         = bus.mem_valid && (bus.mem_branch || bus.mem_branchjalx);
    assign actual     = bus.mem_branchjalx || (bus.mem_branch && bus.mem_alu_branch);
    // A correct taken guess still mispredicts if it fetched from the wrong target.
    assign mispredict = rb && ((actual != bus.mem_pred_taken) ||
                               (actual && bus.mem_pred_taken &&
                                (bus.mem_target != bus.mem_pred_target)));

    assign bus.pcsrc       = mispredict;
    assign bus.ifflush     = mispredict;
    assign bus.idflush     = mispredict;
    assign bus.exflush     = mispredict;
    assign bus.redirect_pc = actual ? bus.mem_target : bus.mem_pc + XLEN'(4);

    always_comb begin
        bus.next_pc = bus.pc_if + XLEN'(4);
        if (mispredict)
            bus.next_pc = bus.redirect_pc;
        else if (bus.pred_taken)
            bus.next_pc = bus.pred_target;
    end

    always_comb begin
        cnt_d = bht_q[idx_m];
        if (bus.mem_branchjalx)
            cnt_d = 2'b11;
        else if (actual && cnt_d != 2'b11)
            cnt_d = cnt_d + 2'b01;
        else if (!actual && cnt_d != 2'b00)
            cnt_d = cnt_d - 2'b01;
    end

    assign br_cnt_d  = (rb && !(&br_cnt_q)) ? br_cnt_q + CNT_W'(1) : br_cnt_q;
    assign mis_cnt_d = (mispredict && !(&mis_cnt_q)) ? mis_cnt_q + CNT_W'(1) : mis_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bht_q     <= {ENTRIES{2'b01}};
            vld_q     <= '0;
            tag_q     <= '0;
            tgt_q     <= '0;
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
            if (rb) begin
                bht_q[idx_m] <= cnt_d;
                // Not-taken conditionals leave the BTB entry alone.
                if (actual) begin
                    vld_q[idx_m] <= 1'b1;
                    tag_q[idx_m] <= tag_m;
                    tgt_q[idx_m] <= bus.mem_target;
                end
            end
        end
    end

    assign bus.br_cnt  = br_cnt_q;
    assign bus.mis_cnt = mis_cnt_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench: dut0 uses dynamic prediction, dut1 static not-taken with 4-bit stats.
module tb_branch_predict_unit;
    logic clk;
    logic rst0, rst1;
    int   checks = 0;
    int   errors = 0;

    branch_predict_unit_if #(.XLEN(32), .CNT_W(32)) if0 ();
    branch_predict_unit_if #(.XLEN(32), .CNT_W(4))  if1 ();

    branch_predict_unit #(.XLEN(32), .IDX_BITS(6), .PREDICT_EN(1'b1), .CNT_W(32)) dut0 (
        .clk(clk), .rst(rst0), .bus(if0.slave));
    branch_predict_unit #(.XLEN(32), .IDX_BITS(6), .PREDICT_EN(1'b0), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst1), .bus(if1.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] pc_if;
        logic        mv, br, alu, jx;
        logic [31:0] mpc, mtgt;
        logic        mpt;
        logic [31:0] mptg;
        logic        e_pt;
        logic [31:0] e_npc;
        logic        e_pcsrc;
        logic [31:0] e_rpc;
        logic [31:0] e_br, e_mis;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic [31:0] pc_if, input logic mv, br, alu, jx,
                                input logic [31:0] mpc, mtgt, input logic mpt,
                                input logic [31:0] mptg, input logic e_pt,
                                input logic [31:0] e_npc, input logic e_pcsrc,
                                input logic [31:0] e_rpc, e_br, e_mis);
        vec_t v;
        v.pc_if = pc_if; v.mv = mv; v.br = br; v.alu = alu; v.jx = jx;
        v.mpc = mpc; v.mtgt = mtgt; v.mpt = mpt; v.mptg = mptg;
        v.e_pt = e_pt; v.e_npc = e_npc; v.e_pcsrc = e_pcsrc; v.e_rpc = e_rpc;
        v.e_br = e_br; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive0(input vec_t v);
        if0.pc_if = v.pc_if;  if0.mem_valid = v.mv; if0.mem_branch = v.br;
        if0.mem_alu_branch = v.alu; if0.mem_branchjalx = v.jx;
        if0.mem_pc = v.mpc; if0.mem_target = v.mtgt;
        if0.mem_pred_taken = v.mpt; if0.mem_pred_target = v.mptg;
    endtask

    task automatic drive1(input logic [31:0] pc, input logic mv, br, alu, input logic mpt);
        if1.pc_if = pc; if1.mem_valid = mv; if1.mem_branch = br;
        if1.mem_alu_branch = alu; if1.mem_branchjalx = 1'b0;
        if1.mem_pc = 32'h100; if1.mem_target = 32'h80;
        if1.mem_pred_taken = mpt; if1.mem_pred_target = 32'h0;
    endtask

    initial begin
        // pc_if mv br alu jx mem_pc target mpt mptg | pt next_pc pcsrc redirect br mis
        vecs[0]  = mk(32'h100, 0,0,0,0, 32'h0,   32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h4,   0, 0);
        vecs[1]  = mk(32'h100, 1,1,1,0, 32'h100, 32'h80,  0, 32'h0,   0, 32'h80,  1, 32'h80,  0, 0);
        vecs[2]  = mk(32'h100, 1,1,1,0, 32'h100, 32'h80,  0, 32'h0,   1, 32'h80,  1, 32'h80,  1, 1);
        vecs[3]  = mk(32'h100, 0,0,0,0, 32'h100, 32'h80,  0, 32'h0,   1, 32'h80,  0, 32'h104, 2, 2);
        vecs[4]  = mk(32'h100, 1,1,0,0, 32'h100, 32'h80,  1, 32'h80,  1, 32'h104, 1, 32'h104, 2, 2);
        vecs[5]  = mk(32'h100, 0,0,0,0, 32'h100, 32'h80,  0, 32'h0,   1, 32'h80,  0, 32'h104, 3, 3);
        vecs[6]  = mk(32'h100, 1,1,1,0, 32'h100, 32'h80,  1, 32'h80,  1, 32'h80,  0, 32'h80,  3, 3);
        vecs[7]  = mk(32'h200, 1,0,0,1, 32'h200, 32'h340, 1, 32'h300, 0, 32'h340, 1, 32'h340, 4, 3);
        vecs[8]  = mk(32'h200, 0,0,0,0, 32'h200, 32'h0,   0, 32'h0,   1, 32'h340, 0, 32'h204, 5, 4);
        vecs[9]  = mk(32'h100, 0,0,0,0, 32'h200, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h204, 5, 4);
        vecs[10] = mk(32'h80,  1,1,0,0, 32'h200, 32'h500, 0, 32'h0,   0, 32'h84,  0, 32'h204, 5, 4);
        vecs[11] = mk(32'h200, 0,0,0,0, 32'h200, 32'h0,   0, 32'h0,   1, 32'h340, 0, 32'h204, 6, 4);
        vecs[12] = mk(32'h200, 1,1,0,0, 32'h200, 32'h500, 1, 32'h340, 1, 32'h204, 1, 32'h204, 6, 4);
        vecs[13] = mk(32'h200, 0,0,0,0, 32'h200, 32'h0,   0, 32'h0,   0, 32'h204, 0, 32'h204, 7, 5);
        vecs[14] = mk(32'h200, 0,1,1,0, 32'h200, 32'h600, 0, 32'h0,   0, 32'h204, 0, 32'h600, 7, 5);
        vecs[15] = mk(32'h200, 0,0,0,0, 32'h200, 32'h0,   0, 32'h0,   0, 32'h204, 0, 32'h204, 7, 5);
        vecs[16] = mk(32'hFFFFFFFC, 1,1,0,0, 32'hFFFFFFFC, 32'h40, 1, 32'h40, 0, 32'h0, 1, 32'h0, 7, 5);
        vecs[17] = mk(32'hFFFFFFFC, 0,0,0,0, 32'hFFFFFFFC, 32'h0,  0, 32'h0,  0, 32'h0, 0, 32'h0, 8, 6);
        vecs[18] = mk(32'h80,  1,0,0,1, 32'h80,  32'h1000, 1, 32'h1000, 0, 32'h84, 0, 32'h1000, 8, 6);
        vecs[19] = mk(32'h80,  0,0,0,0, 32'h80,  32'h0,   0, 32'h0,   1, 32'h1000, 0, 32'h84, 9, 6);

        rst0 = 1'b0;
        rst1 = 1'b0;
        drive0(vecs[0]);
        drive1(32'h100, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        chk("reset pred_taken", {63'd0, if0.pred_taken}, 64'd0);
        chk("reset pcsrc", {63'd0, if0.pcsrc}, 64'd0);
        chk("reset br_cnt", {32'd0, if0.br_cnt}, 64'd0);
        @(negedge clk);
        rst0 = 1'b1;
        rst1 = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive0(vecs[i]);
            #1;
            chk($sformatf("v%0d pred_taken", i), {63'd0, if0.pred_taken}, {63'd0, vecs[i].e_pt});
            chk($sformatf("v%0d next_pc", i), {32'd0, if0.next_pc}, {32'd0, vecs[i].e_npc});
            chk($sformatf("v%0d pcsrc", i), {63'd0, if0.pcsrc}, {63'd0, vecs[i].e_pcsrc});
            chk($sformatf("v%0d flushes", i), {61'd0, if0.ifflush, if0.idflush, if0.exflush},
                {61'd0, {3{vecs[i].e_pcsrc}}});
            chk($sformatf("v%0d redirect_pc", i), {32'd0, if0.redirect_pc}, {32'd0, vecs[i].e_rpc});
            chk($sformatf("v%0d br_cnt", i), {32'd0, if0.br_cnt}, {32'd0, vecs[i].e_br});
            chk($sformatf("v%0d mis_cnt", i), {32'd0, if0.mis_cnt}, {32'd0, vecs[i].e_mis});
        end

        // Asynchronous reset between edges clears stats and tables immediately.
        @(negedge clk);
        drive0(vecs[19]);
        #2 rst0 = 1'b0;
        #1;
        chk("midreset br_cnt", {32'd0, if0.br_cnt}, 64'd0);
        chk("midreset mis_cnt", {32'd0, if0.mis_cnt}, 64'd0);
        chk("midreset pred_taken", {63'd0, if0.pred_taken}, 64'd0);
        chk("midreset next_pc", {32'd0, if0.next_pc}, 64'h84);
        @(negedge clk);
        rst0 = 1'b1;
        drive0(vecs[1]);
        #1;
        chk("postreset pcsrc", {63'd0, if0.pcsrc}, 64'd1);
        @(negedge clk);
        drive0(vecs[0]);
        #1;
        chk("postreset br_cnt", {32'd0, if0.br_cnt}, 64'd1);
        chk("postreset mis_cnt", {32'd0, if0.mis_cnt}, 64'd1);

        // Static not-taken: every taken branch flushes; 4-bit stats saturate at 0xF.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive1(32'h100, 1'b1, 1'b1, 1'b1, 1'b0);
            #1;
            chk($sformatf("s%0d pred_taken", i), {63'd0, if1.pred_taken}, 64'd0);
            chk($sformatf("s%0d pcsrc", i), {63'd0, if1.pcsrc}, 64'd1);
            chk($sformatf("s%0d mis_cnt", i), {60'd0, if1.mis_cnt}, 64'(i));
        end
        @(negedge clk);
        drive1(32'h100, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("sat mis_cnt", {60'd0, if1.mis_cnt}, 64'hF);
        chk("sat br_cnt", {60'd0, if1.br_cnt}, 64'hF);
        chk("static nt pcsrc", {63'd0, if1.pcsrc}, 64'd0);
        chk("static pred_taken", {63'd0, if1.pred_taken}, 64'd0);
        @(negedge clk);
        drive1(32'h100, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("sat br_cnt hold", {60'd0, if1.br_cnt}, 64'hF);
        #2 rst1 = 1'b0;
        #1;
        chk("sat reset mis_cnt", {60'd0, if1.mis_cnt}, 64'd0);
        chk("sat reset br_cnt", {60'd0, if1.br_cnt}, 64'd0);
        @(negedge clk);
        rst1 = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
